// File: rtl/fp_addsub_pipe_if.sv
// Operand/result handshake bundle for the pipelined floating-point adder/subtractor.
// The block under test uses the slave view; the operand issuer and writeback queue use the master view.
interface fp_addsub_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, res, flags
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, res, flags
    );
endinterface

// File: rtl/fp_addsub_pipe.sv
// 3-stage IEEE-754 add/subtract with round-to-nearest-even, flush-to-zero on both ends,
// special-value handling and exception flags. All stages advance together under back-pressure.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic             clk,
    input logic             rst_n,
    fp_addsub_pipe_if.slave bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int M_W  = MAN_W + 1;          // mantissa including hidden bit
    localparam int A_W  = MAN_W + 4;          // mantissa plus guard, round, sticky
    localparam int X_W  = EXP_W + 2;          // signed exponent with headroom
    localparam int LZ_W = $clog2(A_W + 1);
    localparam logic [EXP_W-1:0]        EMAX   = '1;
    localparam logic [EXP_W-1:0]        MAX_SH = EXP_W'(MAN_W + 3);
    localparam logic signed [X_W-1:0]   EMAX_X = {2'b00, EMAX};
    localparam logic signed [X_W-1:0]   ZERO_X = '0;

    typedef enum logic [1:0] {CLS_NUM, CLS_NAN, CLS_INF} cls_e;

    typedef struct packed {
        cls_e             cls;
        logic             invalid;
        logic             sign_l;
        logic             sign_s;
        logic [EXP_W-1:0] exp_l;
        logic [M_W-1:0]   man_l;
        logic [A_W-1:0]   man_s;   // aligned, with guard/round/sticky
    } s1_t;

    typedef struct packed {
        cls_e             cls;
        logic             invalid;
        logic             sign_l;
        logic             eff_sub;
        logic [EXP_W-1:0] exp_l;
        logic [A_W:0]     sum;
        logic [LZ_W-1:0]  lzc;
    } s2_t;

    function automatic logic [LZ_W-1:0] lzc_f(input logic [A_W-1:0] v);
        logic [LZ_W-1:0] n;
        n = LZ_W'(A_W);
        for (int i = 0; i < A_W; i++)
            if (v[i]) n = LZ_W'(A_W - 1 - i);
        return n;
    endfunction

    logic v1, v2, v3, adv;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    logic [W-1:0] res_d, res_q;
    logic [3:0]   flags_d, flags_q;

    assign adv           = !v3 || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = v3;
    assign bus.res       = res_q;
    assign bus.flags     = flags_q;

    // ---------------- S1: unpack, classify, order, align ----------------
    logic                 sign_a, sign_b, a_big, nan_a, nan_b, inf_a, inf_b, snan;
    logic [EXP_W-1:0]     exp_a, exp_b, exp_s, diff, shamt;
    logic [MAN_W-1:0]     frac_a, frac_b;
    logic [W-2:0]         mag_a, mag_b;
    logic [M_W-1:0]       man_a, man_b, man_s;
    logic [M_W+A_W-2:0]   align;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        s1_d   = '0;
        sign_a = bus.a[W-1];
        sign_b = bus.b[W-1] ^ bus.op;
        exp_a  = bus.a[W-2:MAN_W];
        exp_b  = bus.b[W-2:MAN_W];
        frac_a = bus.a[MAN_W-1:0];
        frac_b = bus.b[MAN_W-1:0];
        mag_a  = (exp_a == '0) ? '0 : bus.a[W-2:0];
        mag_b  = (exp_b == '0) ? '0 : bus.b[W-2:0];
        man_a  = (exp_a == '0) ? '0 : {1'b1, frac_a};
        man_b  = (exp_b == '0) ? '0 : {1'b1, frac_b};
        nan_a  = (exp_a == EMAX) && (frac_a != '0);
        nan_b  = (exp_b == EMAX) && (frac_b != '0);
        inf_a  = (exp_a == EMAX) && (frac_a == '0);
        inf_b  = (exp_b == EMAX) && (frac_b == '0);
        snan   = (nan_a && !frac_a[MAN_W-1]) || (nan_b && !frac_b[MAN_W-1]);
        a_big  = (mag_a >= mag_b);

        s1_d.sign_l = a_big ? sign_a : sign_b;
        s1_d.sign_s = a_big ? sign_b : sign_a;
        s1_d.exp_l  = a_big ? exp_a  : exp_b;
        s1_d.man_l  = a_big ? man_a  : man_b;
        exp_s       = a_big ? exp_b  : exp_a;
        man_s       = a_big ? man_b  : man_a;

        diff  = s1_d.exp_l - exp_s;
        shamt = (diff > MAX_SH) ? MAX_SH : diff;
        align = {man_s, (A_W-1)'(0)} >> shamt;
        s1_d.man_s = {align[M_W+A_W-2:M_W], |align[M_W-1:0]};

        if (nan_a || nan_b) begin
            s1_d.cls     = CLS_NAN;
            s1_d.invalid = snan;
        end else if (inf_a && inf_b && (sign_a != sign_b)) begin
            s1_d.cls     = CLS_NAN;
            s1_d.invalid = 1'b1;
        end else if (inf_a || inf_b) begin
            s1_d.cls = CLS_INF;   // the infinite operand is always L
        end else begin
            s1_d.cls = CLS_NUM;
        end
    end

    // ---------------- S2: magnitude add/subtract, leading-zero count ----------------
    always_comb begin
        s2_d         = '0;
        s2_d.cls     = s1_q.cls;
        s2_d.invalid = s1_q.invalid;
        s2_d.sign_l  = s1_q.sign_l;
        s2_d.eff_sub = s1_q.sign_l ^ s1_q.sign_s;
        s2_d.exp_l   = s1_q.exp_l;
        if (s2_d.eff_sub)
            s2_d.sum = {1'b0, s1_q.man_l, 3'b000} - {1'b0, s1_q.man_s};
        else
            s2_d.sum = {1'b0, s1_q.man_l, 3'b000} + {1'b0, s1_q.man_s};
        s2_d.lzc = lzc_f(s2_d.sum[A_W-1:0]);
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [A_W-1:0]        norm;
    logic [M_W-1:0]        man_n;
    logic [M_W:0]          man_r;
    logic                  g, r, st, round_up;
    logic signed [X_W-1:0] exp_n, exp_f;

    always_comb begin
        if (s2_q.sum[A_W]) begin
            norm  = {s2_q.sum[A_W:2], s2_q.sum[1] | s2_q.sum[0]};
            exp_n = {2'b00, s2_q.exp_l} + X_W'(1);
        end else begin
            norm  = s2_q.sum[A_W-1:0] << s2_q.lzc;
            exp_n = {2'b00, s2_q.exp_l} - X_W'(s2_q.lzc);
        end
        man_n    = norm[A_W-1:3];
        g        = norm[2];
        r        = norm[1];
        st       = norm[0];
        round_up = g && (r || st || man_n[0]);
        man_r    = {1'b0, man_n} + (M_W+1)'(round_up);
        exp_f    = exp_n + X_W'(man_r[M_W]);

        res_d   = '0;
        flags_d = '0;
        case (s2_q.cls)
            CLS_NAN: begin
                res_d   = {1'b0, EMAX, 1'b1, (MAN_W-1)'(0)};
                flags_d = {s2_q.invalid, 3'b000};
            end
            CLS_INF: res_d = {s2_q.sign_l, EMAX, MAN_W'(0)};
            default: begin
                if (s2_q.sum == '0) begin
                    res_d = {s2_q.sign_l & ~s2_q.eff_sub, (W-1)'(0)};
                end else if (exp_f >= EMAX_X) begin
                    res_d   = {s2_q.sign_l, EMAX, MAN_W'(0)};
                    flags_d = 4'b0101;
                end else if (exp_f <= ZERO_X) begin
                    res_d   = {s2_q.sign_l, (W-1)'(0)};
                    flags_d = 4'b0011;
                end else begin
                    res_d   = {s2_q.sign_l, exp_f[EXP_W-1:0], man_r[MAN_W-1:0]};
                    flags_d = {3'b000, g | r | st};
                end
            end
        endcase
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else if (adv) begin
            v1 <= bus.in_valid;
            v2 <= v1;
            v3 <= v2;
            if (v2) begin
                res_q   <= res_d;
                flags_q <= flags_d;
            end
        end
    end

    // NOTE: the S1/S2 data registers have no reset; the valid bits alone decide whether they matter.
    always_ff @(posedge clk) begin
        if (adv && bus.in_valid) s1_q <= s1_d;
        if (adv && v1)           s2_q <= s2_d;
    end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754 floating-point adder/subtractor; next generation of the team's combinational single-precision adder.
- Adds a subtract mode, round-to-nearest-even with guard/round/sticky bits, special-value handling and exception flags.
- Uses a valid/ready handshake with full-pipeline back-pressure.
- Sits between operand-issue logic and the result writeback queue of the FPU datapath.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width (hidden bit excluded).
- Derived: W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1; EMAX = 2^EXP_W-1 (all ones).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands a, b, op presented.
- in_ready  out  1  block accepts the operands this cycle.
- a  in  W  operand A {sign, exp, frac}.
- b  in  W  operand B.
- op  in  1  0 = a+b, 1 = a-b (inverts b sign at capture).
- out_valid  out  1  res/flags valid.
- out_ready  in  1  consumer accepts the result.
- res  out  W  rounded result.
- flags  out  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset (async, rst_n=0): all stage valid bits = 0, out_valid = 0, res = 0, flags = 0. Deassertion is synchronised by the reset controller upstream.
- Handshake: adv = !out_valid | out_ready. All three stages shift together when adv = 1, otherwise every stage holds. in_ready = adv (combinational). A transfer occurs when in_valid & in_ready, or when out_valid & out_ready. Bubbles travel as invalid slots.
- Latency: exactly 3 cycles from input transfer to out_valid when not stalled. Throughput is 1 op per cycle.
- S1, unpack/align:
  - Operands with exp = 0 are treated as signed zero (FTZ input).
  - The operand with larger {exp, frac} becomes L; on equality, L = a.
  - d = expL - expS. S mantissa {1, frac} is right-shifted by min(d, MAN_W+3), producing guard, round and sticky bits. Sticky = OR of all bits shifted out.
  - Special-case class and sign are recorded.
- S2, add: effective subtract = signL ^ signS.
  - Sum = L ± S on MAN_W+5 bits; the result is non-negative by construction.
  - A leading-zero count of the sum is registered.
- S3, normalise/round/pack:
  - Carry-out: right shift 1, exp+1, the shifted-out bit ORs into sticky.
  - Otherwise: left shift by lzc, exp - lzc. For lzc > expL, the result is tiny.
  - RNE: round up if G & (R | S | LSB). A mantissa carry after rounding increments exp.
  - inexact = G | R | S before rounding.
- Result rules:
  - Exact zero from a cancelling subtract gives +0.
  - (+0) + (+0) = +0 and (-0) + (-0) = -0.
  - Final exp ≥ EMAX gives ±inf with overflow = 1 and inexact = 1.
  - Final exp ≤ 0 (nonzero) gives signed zero with underflow = 1 and inexact = 1 (FTZ output).
- Specials:
  - Any NaN input, or inf + (-inf) as effective subtract, gives canonical quiet NaN {0, EMAX, 1, 0...}. invalid = 1 only for inf - inf or a signalling NaN (frac MSB = 0); other flags = 0.
  - A single inf, or inf + same-sign inf, gives that inf with flags = 0.
- flags are valid only with out_valid. res and flags are held stable while out_valid & !out_ready.
- Reset mid-operation discards all in-flight operations; no output is produced for them.

Test Plan:
- 1. a=0x3F800000, b=0x3F800000, op=0 -> res=0x40000000, flags=0, out_valid exactly 3 cycles after the transfer.
- 2. a=0x3F800000, b=0x3F800000, op=1 -> res=0x00000000 (+0), flags=0. Also a=0x3F800000, b=0x33800000 (tie) -> res=0x3F800000, inexact=1. Also b=0x34400000 -> res=0x3F800002, inexact=1.
- 3. a=0x7F7FFFFF, b=0x7F7FFFFF -> res=0x7F800000, flags=0b0101. a=0x7F800000, b=0xFF800000 -> res=0x7FC00000, flags=0b1000. a=0x7FC00001, b=1.0 -> res=0x7FC00000, flags=0.
- 4. a=0x00800001, b=0x00800000, op=1 -> res=0x00000000, flags=0b0011. a=0x00000005 (subnormal), b=0x3F800000 -> res=0x3F800000, flags=0.
- 5. Back-pressure: stream 6 back-to-back ops, hold out_ready=0 from cycle 4 for 5 cycles -> in_ready=0 while out_valid & !out_ready, res held stable, no loss or duplication, all results in order after release.
- 6. Pull rst_n low while 3 ops are in flight -> out_valid=0 immediately (async), no stale result after release, the next op completes in 3 cycles.
